// File: rtl/iir_cascade_pkg.sv
// iir_cascade_pkg: shared types, constants and arithmetic helpers for iir_cascade_tdm
//   state_t     : sequencer states IDLE, MAC, WB
//   B0..A2      : coefficient index within a section (coef_addr = section*5 + idx)
//   acc_width() : accumulator width, large enough that five 2W-bit products never overflow
//   sat_w()     : clamp a sign-extended value into the signed w-bit range
package iir_cascade_pkg;
    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;
    localparam logic [2:0] B0 = 3'd0, B1 = 3'd1, B2 = 3'd2, A1 = 3'd3, A2 = 3'd4;
    function automatic int acc_width(input int w);
        return 2 * w + 4;
    endfunction
    function automatic logic signed [127:0] sat_w(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi, lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/iir_cascade_mac.sv
// iir_mac: shared multiply-accumulate unit for the time-multiplexed biquad cascade
//   clk, rst   : clock, asynchronous active-high reset
//   en         : add (or subtract) one product this cycle
//   clr        : zero the accumulator (takes priority over en)
//   neg        : subtract the product (feedback a-terms)
//   sel        : operand select B0..A2 -> x, x1, x2, y1, y2
//   coef       : coefficient multiplied with the selected operand
//   x..y2      : current section input and its four history taps
//   acc        : accumulated sum, acc_width(W) bits
module iir_mac
    import iir_cascade_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = acc_width(W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 neg,
    input  logic [2:0]           sel,
    input  logic signed [W-1:0]  coef,
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  x1,
    input  logic signed [W-1:0]  x2,
    input  logic signed [W-1:0]  y1,
    input  logic signed [W-1:0]  y2,
    output logic signed [AW-1:0] acc
);
    logic signed [W-1:0]   opnd;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  term;
    always_comb begin
        opnd = sel == B0 ? x : sel == B1 ? x1 : sel == B2 ? x2 : sel == A1 ? y1 : y2;
    end
    assign prod = (2*W)'(coef) * (2*W)'(opnd);
    assign term = AW'(prod);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= neg ? acc - term : acc + term;
endmodule

// File: rtl/iir_cascade_tdm.sv
// iir_cascade_tdm: NSEC Direct-Form-I biquads evaluated per sample on one shared MAC
//   clk, rst            : clock, asynchronous active-high reset
//   in, in_valid        : input sample and its valid strobe
//   in_ready            : high in IDLE, sample accepted on in_valid && in_ready && !clr
//   out, out_valid      : filtered sample (held) and its one-cycle new-result pulse
//   clr                 : in IDLE, zero all delay lines (wins over in_valid)
//   coef_we, coef_addr, : coefficient write in IDLE, addr = section*5 + idx (b0,b1,b2,a1,a2)
//   coef_wdata
//   busy                : high while a sample is being computed
// Build option: define IIR_CASCADE_SAT_EN to saturate section results instead of wrapping.
module iir_cascade_tdm
    import iir_cascade_pkg::*;
#(
    parameter int W    = 32,
    parameter int FSW  = 16,
    parameter int NSEC = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] out,
    output logic                out_valid,
    input  logic                clr,
    input  logic                coef_we,
    input  logic [7:0]          coef_addr,
    input  logic signed [W-1:0] coef_wdata,
    output logic                busy
);
    localparam int AW = acc_width(W);
    localparam int NC = 5 * NSEC;
    localparam int SW = NSEC > 1 ? $clog2(NSEC) : 1;
    localparam int CW = $clog2(NC);
    state_t state, state_nx;
    logic [SW-1:0] sec;
    logic [2:0] idx;
    logic [CW-1:0] cidx;
    logic signed [W-1:0] x_cur, y;
    logic signed [W-1:0] coef [NC];
    logic signed [W-1:0] x1 [NSEC];
    logic signed [W-1:0] x2 [NSEC];
    logic signed [W-1:0] y1 [NSEC];
    logic signed [W-1:0] y2 [NSEC];
    logic signed [AW-1:0] acc, shifted;
    logic idle, accept, last;
    assign idle = state == IDLE;
    assign in_ready = idle;
    assign busy = !idle;
    assign accept = idle && in_valid && !clr;
    assign last = sec == SW'(NSEC - 1);
    assign cidx = CW'(int'(sec) * 5 + int'(idx));
    assign shifted = acc >>> FSW;
`ifdef IIR_CASCADE_SAT_EN
    assign y = W'(sat_w(128'(shifted), W));
`else
    assign y = W'(shifted);
`endif
    iir_mac #(.W(W), .AW(AW)) u_mac (
        .clk (clk),
        .rst (rst),
        .en  (state == MAC),
        .clr (state == WB),
        .neg (idx >= A1),
        .sel (idx),
        .coef(coef[cidx]),
        .x   (x_cur),
        .x1  (x1[sec]),
        .x2  (x2[sec]),
        .y1  (y1[sec]),
        .y2  (y2[sec]),
        .acc (acc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    always_comb begin
        state_nx = idle ? (accept ? MAC : IDLE) : state == MAC ? (idx == A2 ? WB : MAC) : (last ? IDLE : MAC);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec       <= '0;
            idx       <= '0;
            x_cur     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NC; i++)
                coef[i] <= i % 5 == 0 ? W'(1) <<< FSW : '0;
            for (int i = 0; i < NSEC; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (idle && coef_we && coef_addr < 8'(NC))
                coef[CW'(coef_addr)] <= coef_wdata;
            if (idle && clr)
                for (int i = 0; i < NSEC; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
            if (accept)
                x_cur <= in;
            if (state == MAC)
                idx <= idx == A2 ? '0 : idx + 3'd1;
            if (state == WB) begin
                x2[sec] <= x1[sec];
                x1[sec] <= x_cur;
                y2[sec] <= y1[sec];
                y1[sec] <= y;
                x_cur   <= y;
                sec     <= last ? '0 : sec + SW'(1);
                if (last) begin
                    out       <= y;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iir_cascade_tdm.sv
// tb_iir_cascade_tdm: randomized self-checking bench for iir_cascade_tdm against a per-sample cascade model
module tb_iir_cascade_tdm;
    localparam int W = 32, FSW = 16, NSEC = 5;
    localparam longint YMAX = 64'sd2147483647, YMIN = -64'sd2147483648;
    logic clk = 0, rst = 1;
    logic signed [W-1:0] din = 0, dout, coef_wdata = 0;
    logic in_valid = 0, in_ready, out_valid, clr = 0, coef_we = 0, busy;
    logic [7:0] coef_addr = 0;
    int vectors = 0, errors = 0;
    longint mc [5*NSEC];
    longint mx1 [NSEC], mx2 [NSEC], my1 [NSEC], my2 [NSEC];

    iir_cascade_tdm #(.W(W), .FSW(FSW), .NSEC(NSEC)) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .out(dout), .out_valid(out_valid), .clr(clr), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 5*NSEC; i++) mc[i] = (i % 5 == 0) ? 65536 : 0;
        for (int k = 0; k < NSEC; k++) begin mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; end
    endtask

    task automatic model_step(input int xin, output int yo);
        longint x, a, y;
        x = xin;
        for (int k = 0; k < NSEC; k++) begin
            a = mc[k*5]*x + mc[k*5+1]*mx1[k] + mc[k*5+2]*mx2[k] - mc[k*5+3]*my1[k] - mc[k*5+4]*my2[k];
            y = a >>> FSW;
`ifdef IIR_CASCADE_SAT_EN
            y = y > YMAX ? YMAX : y < YMIN ? YMIN : y;
`else
            y = longint'(int'(y));
`endif
            mx2[k] = mx1[k]; mx1[k] = x; my2[k] = my1[k]; my1[k] = y;
            x = y;
        end
        yo = int'(x);
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        coef_we = 1; coef_addr = 8'(addr); coef_wdata = data;
        @(negedge clk);
        coef_we = 0;
    endtask

    task automatic set_sec0(input int b0, input int b1, input int b2, input int a1, input int a2);
        int v[5];
        v = '{b0, b1, b2, a1, a2};
        for (int i = 0; i < 5; i++) begin write_coef(i, v[i]); mc[i] = v[i]; end
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        for (int k = 0; k < NSEC; k++) begin mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; end
    endtask

    task automatic start_sample(input int x);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        din = x; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_out(output int got, output bit ok, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        ok = out_valid; got = dout;
    endtask

    task automatic send(input int x, output int got, output bit ok);
        int lat;
        start_sample(x);
        wait_out(got, ok, lat);
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (dout !== 0) begin errors++; $display("FAIL reset_out: got %0d expected 0", dout); end
        vectors++; if (out_valid !== 0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 0;
        model_reset();
    endtask

    task automatic test_passthrough();
        int got, lat, e; bit ok;
        model_step(1000, e);
        start_sample(1000);
        wait_out(got, ok, lat);
        vectors++; if (!ok || lat !== 30) begin errors++; $display("FAIL pass_latency: got %0d ok %b expected 30", lat, ok); end
        vectors++; if (got !== e) begin errors++; $display("FAIL pass_1000: got %0d expected %0d", got, e); end
        vectors++; if (in_ready !== 1 || busy !== 0) begin errors++; $display("FAIL pass_idle_at_out: got ready %b busy %b expected 1 0", in_ready, busy); end
        @(negedge clk);
        vectors++; if (out_valid !== 0 || dout !== 1000) begin errors++; $display("FAIL pass_hold: got valid %b out %0d expected 0 1000", out_valid, dout); end
        model_step(-7, e);
        send(-7, got, ok);
        vectors++; if (!ok || got !== -7) begin errors++; $display("FAIL pass_neg7: got %0d expected -7", got); end
    endtask

    task automatic run_impulse(input string tag);
        int xs[4], ex[4], got, e; bit ok;
        xs = '{65536, 0, 0, 0};
        ex = '{32768, 49152, 57344, 28672};
        for (int i = 0; i < 4; i++) begin
            model_step(xs[i], e);
            send(xs[i], got, ok);
            vectors++;
            if (!ok || got !== ex[i]) begin errors++; $display("FAIL %s[%0d]: got %0d expected %0d", tag, i, got, ex[i]); end
        end
    endtask

    task automatic test_impulse();
        set_sec0(32768, 32768, 32768, -32768, 0);
        do_clr();
        run_impulse("impulse");
    endtask

    task automatic test_clr();
        int got, e; bit ok;
        model_step(12345, e);
        send(12345, got, ok);
        vectors++; if (!ok || got !== e) begin errors++; $display("FAIL clr_prefill: got %0d expected %0d", got, e); end
        @(negedge clk); clr = 1; in_valid = 1; din = 999;
        @(negedge clk);
        vectors++; if (in_ready !== 1 || busy !== 0) begin errors++; $display("FAIL clr_wins: got ready %b busy %b expected 1 0", in_ready, busy); end
        clr = 0; in_valid = 0;
        for (int k = 0; k < NSEC; k++) begin mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; end
        run_impulse("impulse_after_clr");
    endtask

    task automatic test_saturation();
        int got, e; bit ok;
        set_sec0(131072, 0, 0, 0, 0);
        do_clr();
        model_step(1 << 30, e);
        send(1 << 30, got, ok);
`ifdef IIR_CASCADE_SAT_EN
        vectors++; if (!ok || got !== 32'sh7fffffff) begin errors++; $display("FAIL saturation: got %0d expected 2147483647", got); end
`else
        vectors++; if (!ok || got !== 32'sh80000000) begin errors++; $display("FAIL wrap: got %0d expected -2147483648", got); end
`endif
        vectors++; if (got !== e) begin errors++; $display("FAIL sat_model: got %0d expected %0d", got, e); end
        set_sec0(65536, 0, 0, 0, 0);
        do_clr();
    endtask

    task automatic test_protected_writes();
        int got, lat, e; bit ok;
        model_step(500, e);
        start_sample(500);
        write_coef(0, 3 * 65536);
        wait_out(got, ok, lat);
        vectors++; if (!ok || got !== e) begin errors++; $display("FAIL busy_write_ignored: got %0d expected %0d", got, e); end
        @(negedge clk);
        coef_we = 1; coef_addr = 0; coef_wdata = 3 * 65536; din = 500; in_valid = 1;
        @(negedge clk);
        coef_we = 0; in_valid = 0;
        mc[0] = 3 * 65536;
        model_step(500, e);
        wait_out(got, ok, lat);
        vectors++; if (!ok || got !== 1500 || got !== e) begin errors++; $display("FAIL idle_write_same_edge: got %0d expected 1500", got); end
        write_coef(32, 0);
        model_step(11, e);
        send(11, got, ok);
        vectors++; if (!ok || got !== 33) begin errors++; $display("FAIL out_of_range_write: got %0d expected 33", got); end
        set_sec0(65536, 0, 0, 0, 0);
    endtask

    task automatic test_handshake();
        int s[4], ex[4], at[4], got[$], n, cyc;
        set_sec0(32768, 32768, 32768, -32768, 0);
        do_clr();
        for (int i = 0; i < 4; i++) begin
            s[i] = int'($urandom_range(2097152)) - 1048576;
            model_step(s[i], ex[i]);
        end
        n = 0; cyc = 0;
        @(negedge clk);
        din = s[0]; in_valid = 1;
        while ((n < 4 || got.size() < 4) && cyc < 400) begin
            if (out_valid) got.push_back(int'(dout));
            if (in_valid && in_ready) begin
                at[n] = cyc; n++;
                @(posedge clk); #1;
                if (n < 4) din = s[n]; else in_valid = 0;
            end
            @(negedge clk); cyc++;
        end
        in_valid = 0;
        vectors++; if (n !== 4 || got.size() !== 4) begin errors++; $display("FAIL hs_count: got %0d accepts %0d results expected 4 4", n, got.size()); end
        for (int i = 1; i < n; i++) begin
            vectors++; if (at[i] - at[i-1] !== 31) begin errors++; $display("FAIL hs_period[%0d]: got %0d expected 31", i, at[i] - at[i-1]); end
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            vectors++; if (got[i] !== ex[i]) begin errors++; $display("FAIL hs_data[%0d]: got %0d expected %0d", i, got[i], ex[i]); end
        end
    endtask

    task automatic test_random();
        int got, e, x, c; bit ok;
        for (int i = 0; i < 5*NSEC; i++) begin
            c = (i % 5 < 3) ? int'($urandom_range(65536)) - 32768 : int'($urandom_range(32768)) - 16384;
            write_coef(i, c); mc[i] = c;
        end
        do_clr();
        for (int i = 0; i < 8; i++) begin
            x = int'($urandom_range(2097152)) - 1048576;
            model_step(x, e);
            send(x, got, ok);
            vectors++; if (!ok || got !== e) begin errors++; $display("FAIL random[%0d]: got %0d expected %0d", i, got, e); end
        end
    endtask

    task automatic test_reset_mid();
        int got, seen; bit ok;
        set_sec0(32768, 32768, 32768, -32768, 0);
        start_sample(777);
        repeat (11) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        vectors++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d pulses expected 0", seen); end
        vectors++; if (dout !== 0) begin errors++; $display("FAIL rstmid_out: got %0d expected 0", dout); end
        vectors++; if (in_ready !== 1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
        send(1000, got, ok);
        vectors++; if (!ok || got !== 1000) begin errors++; $display("FAIL rstmid_coef_restored: got %0d expected 1000", got); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_impulse();
        test_clr();
        test_saturation();
        test_protected_writes();
        test_handshake();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
